// File: rtl/md_pkg.sv
// md_pkg - shared definitions for the iterative multiply/divide unit.
//   MD_WIDTH   default operand/result half-width
//   MD_CNT_W   iteration counter width for the default width
//   md_state_t controller states (IDLE, CALC, DONE)
//   md_op_t    operation encoding (OP_MUL = 0, OP_DIV = 1)
package md_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = $clog2(MD_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } md_op_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if - request/result bundle between the controller and the
// multiply/divide unit.
//   master (controller): drives start, op, is_signed, operand_a, operand_b;
//                        observes busy, done, hi, lo, div_by_zero
//   slave  (unit)      : the reverse
interface mult_div_unit_if
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
);

    logic             start;
    logic             op;
    logic             is_signed;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, is_signed, operand_a, operand_b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, is_signed, operand_a, operand_b,
        output busy, done, hi, lo, div_by_zero
    );

endinterface

// File: rtl/md_sign_fix.sv
// md_sign_fix - combinational sign handling for signed multiply/divide.
//   Input side : is_signed, op, operand_a, operand_b of the request being
//                accepted -> mag_a, mag_b (magnitudes), neg_main (negate
//                product/quotient), neg_rem (remainder takes dividend sign).
//   Output side: fix_op, fix_neg_main, fix_neg_rem (latched at accept) and
//                raw (unsigned 2*WIDTH result) -> res_hi, res_lo.
module md_sign_fix
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               is_signed,
    input  logic               op,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    output logic [WIDTH-1:0]   mag_a,
    output logic [WIDTH-1:0]   mag_b,
    output logic               neg_main,
    output logic               neg_rem,
    input  logic               fix_op,
    input  logic               fix_neg_main,
    input  logic               fix_neg_rem,
    input  logic [2*WIDTH-1:0] raw,
    output logic [WIDTH-1:0]   res_hi,
    output logic [WIDTH-1:0]   res_lo
);

    logic               sign_a;
    logic               sign_b;
    logic [2*WIDTH-1:0] prod_fixed;

    assign sign_a = is_signed & operand_a[WIDTH-1];
    assign sign_b = is_signed & operand_b[WIDTH-1];

    // -2^(WIDTH-1) maps onto itself, which is the correct unsigned magnitude.
    assign mag_a = sign_a ? -operand_a : operand_a;
    assign mag_b = sign_b ? -operand_b : operand_b;

    assign neg_main = sign_a ^ sign_b;
    assign neg_rem  = sign_a;

    // Product is negated as one 2*WIDTH value; quotient and remainder are
    // negated independently.
    always_comb begin
        prod_fixed = fix_neg_main ? -raw : raw;
        if (fix_op == OP_MUL) begin
            res_hi = prod_fixed[2*WIDTH-1:WIDTH];
            res_lo = prod_fixed[WIDTH-1:0];
        end else begin
            res_hi = fix_neg_rem  ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
            res_lo = fix_neg_main ? -raw[WIDTH-1:0]       : raw[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit - iterative multiply / restoring divide, one bit per cycle.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus.slave  : start/op/is_signed/operand_a/operand_b in,
//                busy/done/hi/lo/div_by_zero out
// Multiply gives the full 2*WIDTH product in {hi, lo}; divide gives
// quotient in lo and remainder in hi. Divide by zero completes in one cycle
// with lo = all ones, hi = operand_a and div_by_zero set.
// Optional macro SIGNED_MD_EN: honours is_signed through md_sign_fix;
// without it is_signed is ignored and everything is unsigned.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_div_unit_if.slave bus
);

    localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    md_state_t          state;
    md_state_t          state_next;
    logic [CNT_W-1:0]   cnt;
    logic               op_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               dbz_q;
    logic               busy_c;
    logic               done_c;
    logic               accept;
    logic               dbz_start;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_try;

    // A request is taken in IDLE and also in DONE (back-to-back issue).
    assign accept    = bus.start && (state != CALC);
    assign dbz_start = accept && (bus.op == OP_DIV) && (bus.operand_b == '0);

`ifdef SIGNED_MD_EN
    logic neg_main;
    logic neg_rem;
    logic neg_main_q;
    logic neg_rem_q;

    md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .is_signed    (bus.is_signed),
        .op           (bus.op),
        .operand_a    (bus.operand_a),
        .operand_b    (bus.operand_b),
        .mag_a        (mag_a),
        .mag_b        (mag_b),
        .neg_main     (neg_main),
        .neg_rem      (neg_rem),
        .fix_op       (op_q),
        .fix_neg_main (neg_main_q),
        .fix_neg_rem  (neg_rem_q),
        .raw          (acc_next),
        .res_hi       (res_hi),
        .res_lo       (res_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (accept) begin
            neg_main_q <= neg_main;
            neg_rem_q  <= neg_rem;
        end
    end
`else
    assign mag_a  = bus.operand_a;
    assign mag_b  = bus.operand_b;
    assign res_hi = acc_next[2*WIDTH-1:WIDTH];
    assign res_lo = acc_next[WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = dbz_start ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state)
            CALC:    busy_c = 1'b1;
            DONE:    done_c = 1'b1;
            default: ;
        endcase
    end

    // acc holds {upper, lower}. Multiply: lower starts as the multiplier and
    // is shifted out LSB first while the partial product grows into upper.
    // Divide: lower starts as the dividend and is shifted out MSB first into
    // the partial remainder (upper); quotient bits shift in at the bottom.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_q} : '0);
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        // The trial remainder always fits in WIDTH bits when it is kept.
        div_try   = div_shift[WIDTH-1:0] - opnd_q;
        if (op_q == OP_MUL) begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end else if (div_shift >= {1'b0, opnd_q}) begin
            acc_next = {div_try, acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // hi/lo only load on entry to DONE, so partial results never show.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            op_q   <= OP_MUL;
            opnd_q <= '0;
            acc    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            dbz_q  <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            op_q  <= bus.op;
            dbz_q <= dbz_start;
            if (bus.op == OP_MUL) begin
                opnd_q <= mag_a;
                acc    <= {{WIDTH{1'b0}}, mag_b};
            end else begin
                opnd_q <= mag_b;
                acc    <= {{WIDTH{1'b0}}, mag_a};
            end
            if (dbz_start) begin
                hi_q <= bus.operand_a;
                lo_q <= '1;
            end
        end else if (state == CALC) begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit - scoreboard bench for mult_div_unit.
// Requests push their expected completion (hi, lo, div_by_zero, done cycle)
// into a queue; a monitor pops and compares on every done pulse.
module tb_mult_div_unit;
    import md_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;
    exp_t sb[$];

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic exp_t mkExp(input logic [31:0] hi, input logic [31:0] lo, input logic dbz);
        exp_t e;
        e.hi  = hi;
        e.lo  = lo;
        e.dbz = dbz;
        e.cyc = 0;
        return e;
    endfunction

    // Reference: plain integer arithmetic on the operands' numeric values.
    function automatic exp_t model(input logic o, input logic s, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      va, vb, q, r;
        logic [63:0] p, qv, rv;
`ifndef SIGNED_MD_EN
        s = 1'b0;
`endif
        e = mkExp(32'h0, 32'h0, 1'b0);
        va = s ? longint'($signed(a)) : longint'({32'h0, a});
        vb = s ? longint'($signed(b)) : longint'({32'h0, b});
        if (o == OP_MUL) begin
            p = s ? 64'(va * vb) : ({32'h0, a} * {32'h0, b});
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'h0) begin
            e.hi  = a;
            e.lo  = 32'hFFFF_FFFF;
            e.dbz = 1'b1;
        end else begin
            q = va / vb;
            r = va % vb;
            qv = 64'(q);
            rv = 64'(r);
            e.lo = qv[31:0];
            e.hi = rv[31:0];
        end
        return e;
    endfunction

    function automatic logic [31:0] pick();
        int k;
        k = $urandom_range(0, 7);
        case (k)
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Entered and left on a falling edge. Waits for busy to drop, then
    // issues one request and scrambles the operands afterwards.
    task automatic applyStimulus(input logic o, input logic s, input logic [31:0] a,
                                 input logic [31:0] b, input exp_t e, output int issued);
        int waited;
        waited = 0;
        issued = -1;
        while (bus.busy && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (bus.busy) begin
            checks++;
            $display("[TB] FAIL issue_timeout: busy=1 after %0d cycles, required 0", waited);
            return;
        end
        bus.start     = 1'b1;
        bus.op        = o;
        bus.is_signed = s;
        bus.operand_a = a;
        bus.operand_b = b;
        issued = cyc;
        e.cyc  = cyc + (((o == OP_DIV) && (b == 32'h0)) ? 1 : W + 1);
        sb.push_back(e);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.op        = 1'($urandom);
        bus.is_signed = 1'($urandom);
        bus.operand_a = 32'($urandom);
        bus.operand_b = 32'($urandom);
    endtask

    task automatic runOp(input logic o, input logic s, input logic [31:0] a,
                         input logic [31:0] b, output int issued);
        applyStimulus(o, s, a, b, model(o, s, a, b), issued);
    endtask

    task automatic dirOp(input logic o, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed, output int issued);
        applyStimulus(o, s, a, b, mkExp(eh, el, ed), issued);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_done: done=1 at cycle %0d, required no completion", cyc);
            end else begin
                e = sb.pop_front();
                checkOutput("done_cycle", 64'(cyc), 64'(e.cyc));
                checkOutput("hi", 64'(bus.hi), 64'(e.hi));
                checkOutput("lo", 64'(bus.lo), 64'(e.lo));
                checkOutput("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
            end
        end
    end

    initial begin
        int   c0, c1, busyCnt, waited;
        logic holdOk;

        bus.start     = 1'b0;
        bus.op        = 1'b0;
        bus.is_signed = 1'b0;
        bus.operand_a = 32'h0;
        bus.operand_b = 32'h0;

        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_flags", 64'({bus.busy, bus.done, bus.div_by_zero}), 64'h0);
        checkOutput("reset_hi", 64'(bus.hi), 64'h0);
        checkOutput("reset_lo", 64'(bus.lo), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 7 x 6 with a stray start in cycle 5; results must hold to cycle 40.
        dirOp(OP_MUL, 1'b0, 32'd7, 32'd6, 32'h0, 32'd42, 1'b0, c0);
        busyCnt = 0;
        holdOk  = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (bus.busy) busyCnt++;
            if (i >= W + 1 && (bus.hi !== 32'h0 || bus.lo !== 32'd42)) holdOk = 1'b0;
            bus.start = (i == 5);
            if (i == 5) begin
                bus.op        = OP_MUL;
                bus.operand_a = 32'd3;
                bus.operand_b = 32'd3;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        checkOutput("mul_busy_cycles", 64'(busyCnt), 64'd32);
        checkOutput("mul_hold_hi_lo", 64'(holdOk), 64'd1);

        dirOp(OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, c0);
        dirOp(OP_DIV, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, c0);
        dirOp(OP_DIV, 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, c0);
        repeat (3) @(negedge clk);
        checkOutput("dbz_held", 64'(bus.div_by_zero), 64'd1);
        dirOp(OP_MUL, 1'b0, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, c0);
        checkOutput("dbz_cleared_on_start", 64'(bus.div_by_zero), 64'd0);

`ifdef SIGNED_MD_EN
        dirOp(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, c0);
        dirOp(OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, c0);
        dirOp(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, c0);
`else
        dirOp(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'h1, 32'h7FFF_FFFC, 1'b0, c0);
        dirOp(OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'h4, 32'hFFFF_FFF1, 1'b0, c0);
        dirOp(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, c0);
`endif
        dirOp(OP_DIV, 1'b1, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, c0);

        // Reset in cycle 10 of a multiply: everything clears before the next edge.
        dirOp(OP_MUL, 1'b0, 32'd9, 32'd9, 32'h0, 32'd81, 1'b0, c0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        checkOutput("midop_reset_flags", 64'({bus.busy, bus.done, bus.div_by_zero}), 64'h0);
        checkOutput("midop_reset_hi", 64'(bus.hi), 64'h0);
        checkOutput("midop_reset_lo", 64'(bus.lo), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dirOp(OP_MUL, 1'b0, 32'd123, 32'd456, 32'h0, 32'd56088, 1'b0, c0);

        // Back-to-back: the second request is taken in the first one's DONE cycle.
        runOp(OP_MUL, 1'b0, 32'h0001_2345, 32'h0000_6789, c0);
        dirOp(OP_MUL, 1'b0, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, c1);
        checkOutput("b2b_issue_cycle", 64'(c1), 64'(c0 + W + 1));

        for (int n = 0; n < 40; n++) begin
            runOp(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick(), c0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        waited = 0;
        while (bus.busy && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
